mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access pipeline stage. Consumes the execute stage's outputs (destination register, ALU result/address, LSU op, load/store select, sign-extend flag, store data).
- Performs at most one data-bus transaction per instruction with a single outstanding request.
- Returns the writeback register number and value, and stalls the core while the transaction is in flight.

Parameters:
- ADDR_WIDTH, 32, data bus address width
- DATA_WIDTH, 32, register/data width (byte lanes = DATA_WIDTH/8 = 4)
- REGNO_WIDTH, 5, register number width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- i_exec_stall  in  1  execute stall from the control unit
- i_fetch_stall  in  1  fetch stall from the control unit
- o_mem_stall  out  1  stage busy with a bus transaction
- o_addr_error  out  1  misaligned-access pulse
- i_rd_no  in  REGNO_WIDTH  destination register from execute
- i_alu_result  in  DATA_WIDTH  ALU result; the effective address for memory ops
- i_lsu_op  in  2  IDLE=0, BYTE=1, HWORD=2, WORD=3
- i_lsu_lns  in  1  1 = load, 0 = store
- i_lsu_ext  in  1  sign-extend load data
- i_mem_data  in  DATA_WIDTH  store data (unaligned rt value)
- o_rd_no  out  REGNO_WIDTH  writeback register; 0 means no write
- o_rd_val  out  DATA_WIDTH  writeback value
- o_bus_addr  out  ADDR_WIDTH  word-aligned bus address
- o_bus_cmd  out  1  request valid
- o_bus_rnw  out  1  1 = read
- o_bus_ben  out  4  byte enables
- o_bus_wdata  out  DATA_WIDTH  lane-aligned write data
- i_bus_accept  in  1  request accepted this cycle
- i_bus_rdy  in  1  read data valid this cycle
- i_bus_rdata  in  DATA_WIDTH  read data

Behaviour:
- core_stall = i_exec_stall | i_fetch_stall | o_mem_stall. Inputs are captured on the clk edge only when core_stall = 0.
- Reset values:
  - FSM state IDLE.
  - All outputs and capture registers are 0, including o_rd_no, o_rd_val, o_bus_*, o_addr_error and o_mem_stall.
- Byte lanes are little-endian: byte at addr[1:0] = n occupies bits 8n+7:8n. o_bus_addr = {addr[31:2], 2'b00}.
- Enables and write data:
  - BYTE: ben = 1 << addr[1:0]; wdata = data[7:0] replicated x4.
  - HWORD: ben = 4'b0011 or 4'b1100 by addr[1]; wdata = data[15:0] replicated x2.
  - WORD: ben = 4'b1111; wdata = data.
- Misalignment: HWORD with addr[0] = 1, or WORD with addr[1:0] != 0. Checked at capture.
  - o_addr_error = 1 for exactly one cycle.
  - No bus command is issued.
  - o_rd_no = 0.
  - No stall.
- Non-memory op (i_lsu_op = IDLE) at capture: o_rd_no = i_rd_no and o_rd_val = i_alu_result, registered, so latency is 1 cycle.
- FSM:
  - IDLE: on capture of an aligned memory op, register address/ben/wdata/rnw, set o_rd_no = 0, go to CMD.
  - CMD: o_bus_cmd = 1; bus outputs hold stable until i_bus_accept.
    - Store accepted: go to IDLE.
    - Load accepted: go to WAIT.
  - WAIT: o_bus_cmd = 0. On i_bus_rdy:
    - Extract the lane selected by addr.
    - Zero- or sign-extend (sign when i_lsu_ext = 1).
    - o_rd_val = extracted value; o_rd_no = captured rd.
    - Go to IDLE.
  - i_bus_accept and i_bus_rdy in the same cycle while in CMD on a load: data is taken immediately and the FSM goes directly to IDLE.
- o_mem_stall = (state != IDLE), combinational from state. The completion cycle updates o_rd_*; stall drops on the following cycle.
- A load's register write appears on o_rd_no only on the cycle after data return and persists until the next capture.
- Stores never write a register: o_rd_no = 0.
- i_bus_accept/i_bus_rdy in IDLE, and i_bus_rdy in CMD on a store, are ignored.
- External stall while in IDLE: outputs hold their values; the input is not captured.
- Reset mid-transaction: o_bus_cmd and o_mem_stall drop asynchronously; the bus tolerates abandoned requests.

Test Plan:
- ALU passthrough: i_lsu_op = IDLE, rd = 5, result = 0x1234 -> next cycle o_rd_no = 5, o_rd_val = 0x1234, no bus cmd, stall 0.
- Signed byte load: addr 0x103, ext = 1, bus returns 0x80AABBCC after 2-cycle accept and 3-cycle data delay -> o_bus_addr = 0x100, ben = 1000, stall held 5 cycles, o_rd_val = 0xFFFFFF80.
- Unsigned halfword load: addr 0x202, ext = 0, rdata = 0xBEEF1234 -> ben = 1100, o_rd_val = 0x0000BEEF.
- Halfword store: addr 0x302, data 0xCAFE5A5A -> wdata = 0x5A5A5A5A, ben = 1100, rnw = 0, o_rd_no = 0, stall drops after accept.
- Misaligned word at 0x401 -> o_addr_error one-cycle pulse, o_bus_cmd never asserted, o_rd_no = 0.
- Reset asserted in WAIT -> o_mem_stall = 0 and o_bus_cmd = 0 immediately; after release, a fresh WORD load at 0x500 completes normally.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one outstanding data-bus transaction per
// instruction, lane steering for stores, lane extraction/extension for loads.
module mem_access #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REGNO_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_exec_stall,
  input  logic                   i_fetch_stall,
  output logic                   o_mem_stall,
  output logic                   o_addr_error,
  input  logic [REGNO_WIDTH-1:0] i_rd_no,
  input  logic [DATA_WIDTH-1:0]  i_alu_result,
  input  logic [1:0]             i_lsu_op,
  input  logic                   i_lsu_lns,
  input  logic                   i_lsu_ext,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  output logic [REGNO_WIDTH-1:0] o_rd_no,
  output logic [DATA_WIDTH-1:0]  o_rd_val,
  output logic [ADDR_WIDTH-1:0]  o_bus_addr,
  output logic                   o_bus_cmd,
  output logic                   o_bus_rnw,
  output logic [3:0]             o_bus_ben,
  output logic [DATA_WIDTH-1:0]  o_bus_wdata,
  input  logic                   i_bus_accept,
  input  logic                   i_bus_rdy,
  input  logic [DATA_WIDTH-1:0]  i_bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} state_e;
  typedef enum logic [1:0] {OP_IDLE, OP_BYTE, OP_HWORD, OP_WORD} lsu_op_e;

  state_e                 state;
  lsu_op_e                op;
  lsu_op_e                op_q;
  logic [REGNO_WIDTH-1:0] rd_q;
  logic [1:0]             lane_q;
  logic                   ext_q;
  logic                   core_stall;
  logic                   misaligned;
  logic [3:0]             ben_n;
  logic [DATA_WIDTH-1:0]  wdata_n;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  load_val;

  assign o_mem_stall = (state != ST_IDLE);
  assign core_stall  = i_exec_stall | i_fetch_stall | o_mem_stall;

  always_comb begin
    op         = lsu_op_e'(i_lsu_op);
    misaligned = ((op == OP_HWORD) && i_alu_result[0]) ||
                 ((op == OP_WORD) && (i_alu_result[1:0] != 2'b00));
    ben_n      = '0;
    wdata_n    = '0;
    case (op)
      OP_BYTE: begin
        ben_n   = 4'b0001 << i_alu_result[1:0];
        wdata_n = {(DATA_WIDTH/8){i_mem_data[7:0]}};
      end
      OP_HWORD: begin
        ben_n   = i_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_n = {(DATA_WIDTH/16){i_mem_data[15:0]}};
      end
      OP_WORD: begin
        ben_n   = 4'b1111;
        wdata_n = i_mem_data;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per the captured flag.
  always_comb begin
    shifted  = i_bus_rdata >> {lane_q, 3'b000};
    load_val = i_bus_rdata;
    case (op_q)
      OP_BYTE:  load_val = {{(DATA_WIDTH-8){ext_q & shifted[7]}}, shifted[7:0]};
      OP_HWORD: load_val = {{(DATA_WIDTH-16){ext_q & shifted[15]}}, shifted[15:0]};
      default:  load_val = i_bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_IDLE;
      rd_q         <= '0;
      lane_q       <= '0;
      ext_q        <= 1'b0;
      o_addr_error <= 1'b0;
      o_rd_no      <= '0;
      o_rd_val     <= '0;
      o_bus_addr   <= '0;
      o_bus_cmd    <= 1'b0;
      o_bus_rnw    <= 1'b0;
      o_bus_ben    <= '0;
      o_bus_wdata  <= '0;
    end else begin
      o_addr_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!core_stall) begin
            if (op == OP_IDLE) begin
              o_rd_no  <= i_rd_no;
              o_rd_val <= i_alu_result;
            end else if (misaligned) begin
              o_rd_no      <= '0;
              o_addr_error <= 1'b1;
            end else begin
              o_rd_no     <= '0;
              o_bus_addr  <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
              o_bus_ben   <= ben_n;
              o_bus_wdata <= wdata_n;
              o_bus_rnw   <= i_lsu_lns;
              o_bus_cmd   <= 1'b1;
              rd_q        <= i_rd_no;
              lane_q      <= i_alu_result[1:0];
              op_q        <= op;
              ext_q       <= i_lsu_ext;
              state       <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (i_bus_accept) begin
            o_bus_cmd <= 1'b0;
            if (!o_bus_rnw) begin
              state <= ST_IDLE;
            end else if (i_bus_rdy) begin
              o_rd_no  <= rd_q;
              o_rd_val <= load_val;
              state    <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_bus_rdy) begin
            o_rd_no  <= rd_q;
            o_rd_val <= load_val;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with hand-computed expectations.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_exec_stall = 1'b0, i_fetch_stall = 1'b0;
  logic        o_mem_stall, o_addr_error;
  logic [4:0]  i_rd_no = '0;
  logic [31:0] i_alu_result = '0;
  logic [1:0]  i_lsu_op = '0;
  logic        i_lsu_lns = 1'b0, i_lsu_ext = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [4:0]  o_rd_no;
  logic [31:0] o_rd_val;
  logic [31:0] o_bus_addr;
  logic        o_bus_cmd, o_bus_rnw;
  logic [3:0]  o_bus_ben;
  logic [31:0] o_bus_wdata;
  logic        i_bus_accept = 1'b0, i_bus_rdy = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  int total = 0;
  int bad   = 0;
  int n;
  logic cmd_seen;

  mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REGNO_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
    .o_mem_stall(o_mem_stall), .o_addr_error(o_addr_error),
    .i_rd_no(i_rd_no), .i_alu_result(i_alu_result), .i_lsu_op(i_lsu_op),
    .i_lsu_lns(i_lsu_lns), .i_lsu_ext(i_lsu_ext), .i_mem_data(i_mem_data),
    .o_rd_no(o_rd_no), .o_rd_val(o_rd_val),
    .o_bus_addr(o_bus_addr), .o_bus_cmd(o_bus_cmd), .o_bus_rnw(o_bus_rnw),
    .o_bus_ben(o_bus_ben), .o_bus_wdata(o_bus_wdata),
    .i_bus_accept(i_bus_accept), .i_bus_rdy(i_bus_rdy), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    i_lsu_op = 2'd0; i_rd_no = '0; i_alu_result = '0;
    i_lsu_lns = 1'b0; i_lsu_ext = 1'b0; i_mem_data = '0;
  endtask

  // Present one instruction for a single capture edge, then fall back to a NOP.
  task automatic issue(input logic [1:0] op, input logic lns, input logic ext,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    i_lsu_op = op; i_lsu_lns = lns; i_lsu_ext = ext;
    i_rd_no = rd; i_alu_result = addr; i_mem_data = data;
    tick();
    nop();
  endtask

  // Bus model: accept on stall cycle acc, data rdy_gap cycles later; bounded.
  task automatic serve(input int acc, input int rdy_gap, input logic [31:0] rdata,
                       output int cycles);
    cycles = 0;
    i_bus_rdata = rdata;
    while (o_mem_stall && cycles < 20) begin
      cycles++;
      i_bus_accept = (cycles == acc);
      i_bus_rdy    = (cycles == acc + rdy_gap);
      tick();
    end
    i_bus_accept = 1'b0;
    i_bus_rdy    = 1'b0;
    if (cycles >= 20) chk("bus_timeout", 32'(cycles), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(o_mem_stall), 32'd0);
    chk("rst_cmd",   32'(o_bus_cmd), 32'd0);
    chk("rst_rd_no", 32'(o_rd_no), 32'd0);
    chk("rst_rd_val", o_rd_val, 32'd0);
    chk("rst_addr",  o_bus_addr, 32'd0);
    chk("rst_err",   32'(o_addr_error), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU passthrough
    issue(2'd0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
    chk("pass_rd_no", 32'(o_rd_no), 32'd5);
    chk("pass_rd_val", o_rd_val, 32'h1234);
    chk("pass_cmd", 32'(o_bus_cmd), 32'd0);
    chk("pass_stall", 32'(o_mem_stall), 32'd0);

    // External stall: nothing captured, outputs hold
    @(negedge clk);
    i_exec_stall = 1'b1; i_rd_no = 5'd9; i_alu_result = 32'h99;
    tick();
    chk("xstall_rd_no", 32'(o_rd_no), 32'd5);
    chk("xstall_rd_val", o_rd_val, 32'h1234);
    i_exec_stall = 1'b0;
    nop();

    // Signed byte load, 2-cycle accept, 3-cycle data
    issue(2'd1, 1'b1, 1'b1, 5'd7, 32'h103, 32'h0);
    chk("lb_addr", o_bus_addr, 32'h100);
    chk("lb_ben",  32'(o_bus_ben), 32'h8);
    chk("lb_rnw",  32'(o_bus_rnw), 32'd1);
    chk("lb_cmd",  32'(o_bus_cmd), 32'd1);
    chk("lb_rd_no_busy", 32'(o_rd_no), 32'd0);
    serve(2, 3, 32'h80AABBCC, n);
    chk("lb_stall_cycles", 32'(n), 32'd5);
    chk("lb_rd_no", 32'(o_rd_no), 32'd7);
    chk("lb_rd_val", o_rd_val, 32'hFFFFFF80);
    chk("lb_cmd_done", 32'(o_bus_cmd), 32'd0);

    // Unsigned halfword load, upper lane
    issue(2'd2, 1'b1, 1'b0, 5'd8, 32'h202, 32'h0);
    chk("lh_ben", 32'(o_bus_ben), 32'hC);
    chk("lh_addr", o_bus_addr, 32'h200);
    serve(1, 1, 32'hBEEF1234, n);
    chk("lh_rd_no", 32'(o_rd_no), 32'd8);
    chk("lh_rd_val", o_rd_val, 32'h0000BEEF);

    // Unsigned byte load with same-cycle accept and data
    issue(2'd1, 1'b1, 1'b0, 5'd10, 32'h701, 32'h0);
    chk("lbu_ben", 32'(o_bus_ben), 32'h2);
    serve(1, 0, 32'h1234F678, n);
    chk("lbu_cycles", 32'(n), 32'd1);
    chk("lbu_rd_val", o_rd_val, 32'h000000F6);
    chk("lbu_rd_no", 32'(o_rd_no), 32'd10);

    // Halfword store; rdy during CMD must be ignored
    issue(2'd2, 1'b0, 1'b0, 5'd11, 32'h302, 32'hCAFE5A5A);
    chk("sh_wdata", o_bus_wdata, 32'h5A5A5A5A);
    chk("sh_ben", 32'(o_bus_ben), 32'hC);
    chk("sh_rnw", 32'(o_bus_rnw), 32'd0);
    chk("sh_rd_no", 32'(o_rd_no), 32'd0);
    serve(1, 0, 32'hDEADBEEF, n);
    chk("sh_cycles", 32'(n), 32'd1);
    chk("sh_stall", 32'(o_mem_stall), 32'd0);
    chk("sh_rd_no_after", 32'(o_rd_no), 32'd0);

    // Byte store lane 1
    issue(2'd1, 1'b0, 1'b0, 5'd0, 32'h001, 32'h000000A5);
    chk("sb_wdata", o_bus_wdata, 32'hA5A5A5A5);
    chk("sb_ben", 32'(o_bus_ben), 32'h2);
    serve(1, 0, 32'h0, n);

    // Misaligned word: one-cycle error pulse, no command
    issue(2'd0, 1'b0, 1'b0, 5'd4, 32'h44, 32'h0);
    issue(2'd3, 1'b1, 1'b0, 5'd6, 32'h401, 32'h0);
    cmd_seen = o_bus_cmd;
    chk("mis_err", 32'(o_addr_error), 32'd1);
    chk("mis_rd_no", 32'(o_rd_no), 32'd0);
    chk("mis_stall", 32'(o_mem_stall), 32'd0);
    tick();
    cmd_seen = cmd_seen | o_bus_cmd;
    chk("mis_err_drop", 32'(o_addr_error), 32'd0);
    chk("mis_cmd", 32'(cmd_seen), 32'd0);

    // Misaligned halfword
    issue(2'd2, 1'b1, 1'b0, 5'd6, 32'h203, 32'h0);
    chk("mish_err", 32'(o_addr_error), 32'd1);
    chk("mish_cmd", 32'(o_bus_cmd), 32'd0);

    // Reset in WAIT, then a fresh word load
    issue(2'd3, 1'b1, 1'b0, 5'd3, 32'h600, 32'h0);
    i_bus_accept = 1'b1;
    tick();
    i_bus_accept = 1'b0;
    chk("wait_stall", 32'(o_mem_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 32'(o_mem_stall), 32'd0);
    chk("arst_cmd", 32'(o_bus_cmd), 32'd0);
    rst = 1'b0;
    issue(2'd3, 1'b1, 1'b0, 5'd12, 32'h500, 32'h0);
    chk("lw_addr", o_bus_addr, 32'h500);
    chk("lw_ben", 32'(o_bus_ben), 32'hF);
    serve(1, 1, 32'h11223344, n);
    chk("lw_cycles", 32'(n), 32'd2);
    chk("lw_rd_no", 32'(o_rd_no), 32'd12);
    chk("lw_rd_val", o_rd_val, 32'h11223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
